// File: rtl/clock_core.sv
// Time-of-day and alarm register block: BCD hh:mm:ss counter driven by a 1 Hz tick,
// five-state set/alarm mode FSM and a single-cycle alarm_hit pulse.
module clock_core #(
    parameter int unsigned ALARM_H_INIT = 7,
    parameter int unsigned ALARM_M_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       second,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_alarm,
    output logic [1:0] hour_t,
    output logic [3:0] hour_o,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic [2:0] mode,
    output logic       alarm_en,
    output logic       alarm_hit
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } state_t;

    localparam logic [5:0] ALARM_H_RST = {2'(ALARM_H_INIT / 10), 4'(ALARM_H_INIT % 10)};
    localparam logic [6:0] ALARM_M_RST = {3'(ALARM_M_INIT / 10), 4'(ALARM_M_INIT % 10)};
    localparam logic [6:0] BCD_59      = {3'd5, 4'd9};

    state_t state, state_nxt;

    logic       time_run, clr_sec, inc_h, inc_m, inc_ah, inc_am, tick;
    logic [5:0] alarm_h, alarm_h_nxt;
    logic [6:0] alarm_m, alarm_m_nxt;
    logic [5:0] h_cur, h_inc, h_nxt;
    logic [6:0] m_cur, m_inc, m_nxt;
    logic [6:0] s_cur, s_inc, s_nxt;
    logic       hit_nxt;

    // BCD hour increment, 23 wraps to 00
    function automatic logic [5:0] hour_next(input logic [5:0] h);
        if (h == {2'd2, 4'd3})
            return '0;
        else if (h[3:0] == 4'd9)
            return {h[5:4] + 2'd1, 4'd0};
        else
            return {h[5:4], h[3:0] + 4'd1};
    endfunction

    // BCD minute/second increment, 59 wraps to 00
    function automatic logic [6:0] sixty_next(input logic [6:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[6:4] == 3'd5)
                return '0;
            else
                return {v[6:4] + 3'd1, 4'd0};
        end
        return {v[6:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (key_mode) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_AH;
                SET_AH:  state_nxt = SET_AM;
                SET_AM:  state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // key_inc is discarded whenever key_mode is sampled in the same cycle
    always_comb begin
        mode     = state;
        time_run = (state == RUN) || (state == SET_AH) || (state == SET_AM);
        clr_sec  = (state == RUN) && key_mode;
        inc_h    = (state == SET_H)  && key_inc && !key_mode;
        inc_m    = (state == SET_M)  && key_inc && !key_mode;
        inc_ah   = (state == SET_AH) && key_inc && !key_mode;
        inc_am   = (state == SET_AM) && key_inc && !key_mode;
    end

    assign tick  = time_run && second;
    assign h_cur = {hour_t, hour_o};
    assign m_cur = {min_t, min_o};
    assign s_cur = {sec_t, sec_o};
    assign h_inc = hour_next(h_cur);
    assign m_inc = sixty_next(m_cur);
    assign s_inc = sixty_next(s_cur);

    // Ticks only occur in run modes and key increments only in set modes, so they never collide
    always_comb begin
        h_nxt = h_cur;
        m_nxt = m_cur;
        s_nxt = s_cur;
        if (tick) begin
            s_nxt = s_inc;
            if (s_cur == BCD_59) begin
                m_nxt = m_inc;
                if (m_cur == BCD_59)
                    h_nxt = h_inc;
            end
        end
        if (inc_h)
            h_nxt = h_inc;
        if (inc_m)
            m_nxt = m_inc;
        if (clr_sec)
            s_nxt = '0;
        hit_nxt = tick && (s_cur == BCD_59) && alarm_en &&
                  (h_nxt == alarm_h) && (m_nxt == alarm_m);
        alarm_h_nxt = inc_ah ? hour_next(alarm_h) : alarm_h;
        alarm_m_nxt = inc_am ? sixty_next(alarm_m) : alarm_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {hour_t, hour_o} <= '0;
            {min_t, min_o}   <= '0;
            {sec_t, sec_o}   <= '0;
            alarm_h          <= ALARM_H_RST;
            alarm_m          <= ALARM_M_RST;
            alarm_en         <= 1'b0;
            alarm_hit        <= 1'b0;
        end else begin
            {hour_t, hour_o} <= h_nxt;
            {min_t, min_o}   <= m_nxt;
            {sec_t, sec_o}   <= s_nxt;
            alarm_h          <= alarm_h_nxt;
            alarm_m          <= alarm_m_nxt;
            alarm_en         <= alarm_en ^ key_alarm;
            alarm_hit        <= hit_nxt;
        end
    end

endmodule

// File: doc/clock_core.md
# clock_core

Time-of-day and alarm register block for the digital clock. Sits directly downstream of the 1 Hz divider and the key debouncers: consumes the one-cycle `second` tick and debounced one-cycle key pulses, keeps hh:mm:ss in BCD for the seven-segment scanner, and raises the `alarm_hit` pulse that drives the alarm/light controller's `flag` input. Holds a five-state mode FSM for setting time and alarm.

## Interface
- ALARM_H_INIT, 7: alarm hour loaded at reset (0–23).
- ALARM_M_INIT, 0: alarm minute loaded at reset (0–59).

- clk  in  1  system clock, 40 MHz; the single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- second  in  1  one-cycle pulse, once per second, from the divider.
- key_mode  in  1  one-cycle debounced pulse; advances mode.
- key_inc  in  1  one-cycle debounced pulse; increments selected field.
- key_alarm  in  1  one-cycle debounced pulse; toggles alarm_en.
- hour_t  out  2  hour tens, BCD 0–2.
- hour_o  out  4  hour ones, BCD 0–9.
- min_t  out  3  minute tens, BCD 0–5.
- min_o  out  4  minute ones, BCD.
- sec_t  out  3  second tens, BCD 0–5.
- sec_o  out  4  second ones, BCD.
- mode  out  3  current state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_AH, 4 SET_AM.
- alarm_en  out  1  alarm armed.
- alarm_hit  out  1  one-cycle pulse when running time reaches alarm time.

## Operation
- Reset (rst=1 on a clk edge): time 00:00:00, alarm ALARM_H_INIT:ALARM_M_INIT, mode=RUN, alarm_en=0, alarm_hit=0. Reset wins over every other input, including mid-set.
- FSM on key_mode: RUN→SET_H→SET_M→SET_AH→SET_AM→RUN. No other transitions.
- Entering SET_H clears seconds to 00. In SET_H and SET_M time is frozen: `second` ignored.
- In RUN, SET_AH, SET_AM time counts on every `second` pulse.
- Count rules (BCD, per digit): sec_o 9→0 carries to sec_t; sec 59→00 carries to minute; min 59→00 carries to hour; hour 23→00. Hour ones wraps at 9 when tens <2, at 3 when tens=2.
- key_inc: SET_H hour+1 (23→00); SET_M minute+1 (59→00, no carry into hour); SET_AH alarm hour+1 (23→00); SET_AM alarm minute+1 (59→00, no carry). Ignored in RUN.
- key_alarm toggles alarm_en in any mode.
- Outputs show the time registers in every mode; alarm value is internal (not displayed by this block).
- alarm_hit: asserted for exactly one cycle when a `second`-driven increment produces hh:mm:00 equal to the alarm hh:mm and alarm_en=1. Time entered via key_inc never fires alarm_hit.

## Timing
- All outputs registered. Digits reflect a `second` pulse on the edge after the pulse is sampled (latency 1 cycle).
- alarm_hit asserts on the same edge the matching time appears on the outputs; deasserts next cycle.
- mode changes 1 cycle after key_mode sampled.
- Simultaneous key_mode and key_inc: mode advances, key_inc discarded.
- Simultaneous `second` and key_inc in SET_AH/SET_AM: both applied in the same cycle (independent registers).
- Simultaneous key_alarm with a matching tick: alarm_hit uses the pre-toggle alarm_en.
- `second` and key pulses longer than one cycle are treated as one event per asserted cycle (inputs are required to be single-cycle).

## Test plan
- Reset: rst high 2 cycles mid-count → 00:00:00, mode=0, alarm_en=0, alarm_hit=0 next cycle.
- Rollover: load 23:59:59 via set + ticks, one `second` → 00:00:00 one cycle later, no alarm_hit with alarm_en=0.
- Setting: key_mode once, key_inc ×25 → hour 01; key_mode, key_inc ×61 → minute 01; ticks in SET_H/SET_M leave sec at 00.
- Alarm: alarm set 00:01, alarm_en=1, run from 00:00:58 → alarm_hit single-cycle pulse coincident with 00:01:00; none at 00:01:01.
- Simultaneous: key_mode+key_inc same cycle in SET_H → mode=2, hour unchanged; `second`+key_inc in SET_AH → time and alarm hour both advance.
- Reset mid-set: mode=3 with modified alarm, rst → mode=0, alarm back to 07:00.
